// File: rtl/gate_seq_pkg.sv
// Shared types and helpers for the gate sequencer/checker: FSM states,
// number of input vectors and the expected-result function of the gate.
package gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPORT = 2'd2
    } state_e;

    localparam int NUM_VEC = 4;

    function automatic logic exp_and(input logic a, input logic b);
        return a & b;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Counts cycles while enabled and flags the last cycle of a hold period;
// wraps to zero after the last cycle so the next vector starts cleanly.
module hold_timer #(
    parameter int HOLD_CYCLES = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    assign last = (count_q == LAST_CNT);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = last ? '0 : count_q + CW'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, matching real hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/gate_sequencer_checker.sv
// Drives a two-input gate through 00,01,10,11, holds each vector for
// HOLD_CYCLES cycles and checks Y against AND on the last cycle of each hold.
module gate_sequencer_checker
    import gate_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 100,
    parameter int ERR_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Y,
    output logic             A,
    output logic             B,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       err_vec
);

    state_e           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic             a_q, a_d, b_q, b_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [3:0]       err_vec_q, err_vec_d;
    logic             timer_clr, timer_en, timer_last;

    hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .en   (timer_en),
        .last (timer_last)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        err_vec_d   = err_vec_q;
        timer_clr   = 1'b0;
        timer_en    = 1'b0;

        case (state_q)
            IDLE: begin
                timer_clr = 1'b1;
                if (start) begin
                    pass_d      = 1'b0;
                    err_count_d = '0;
                    err_vec_d   = '0;
                    vec_d       = '0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                timer_en = 1'b1;
                if (timer_last) begin
                    // Y is combinational in A/B, so the registered A/B on this
                    // cycle are the inputs that produced the sampled Y.
                    if (Y != exp_and(a_q, b_q)) begin
                        err_vec_d[vec_q] = 1'b1;
                        if (err_count_q != {ERR_W{1'b1}}) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                    end
                    if (vec_q == 2'(NUM_VEC - 1)) begin
                        pass_d  = (err_count_d == '0);
                        state_d = REPORT;
                    end else begin
                        vec_d = vec_q + 2'd1;
                    end
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        a_d    = (state_d == HOLD) & vec_d[1];
        b_d    = (state_d == HOLD) & vec_d[0];
        busy_d = (state_d == HOLD);
        done_d = (state_d == REPORT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            err_vec_q   <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            err_vec_q   <= err_vec_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign err_vec   = err_vec_q;

endmodule

// File: tb/tb_gate_sequencer_checker.sv
// Bench for gate_sequencer_checker: three instances (hold 4, 2, 1) each drive a
// gate modelled as a 4-entry truth table; results are predicted from the table.
module tb_gate_sequencer_checker;

    logic       clk;
    logic       rst       [3];
    logic       start     [3];
    logic       y_i       [3];
    logic       a_o       [3];
    logic       b_o       [3];
    logic       busy_o    [3];
    logic       done_o    [3];
    logic       pass_o    [3];
    logic [2:0] ec_o      [3];
    logic [3:0] ev_o      [3];
    logic [3:0] tt        [3];

    int n_vec = 0;
    int n_err = 0;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        gate_sequencer_checker #(
            .HOLD_CYCLES((i == 0) ? 4 : ((i == 1) ? 2 : 1)),
            .ERR_W      (3)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[i]),
            .start     (start[i]),
            .Y         (y_i[i]),
            .A         (a_o[i]),
            .B         (b_o[i]),
            .busy      (busy_o[i]),
            .done      (done_o[i]),
            .pass      (pass_o[i]),
            .err_count (ec_o[i]),
            .err_vec   (ev_o[i])
        );
        // Gate under check: its output for inputs {A,B} is truth-table bit {A,B}.
        assign y_i[i] = tt[i][{a_o[i], b_o[i]}];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int hold_of(input int idx);
        return (idx == 0) ? 4 : ((idx == 1) ? 2 : 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete run on instance idx with gate truth table tbl.
    // mode 0: start pulsed; 1: extra start pulse during HOLD; 2: start left high.
    task automatic run_check(input int idx, input logic [3:0] tbl, input int mode);
        int         h;
        logic [3:0] exp_ev;
        int         exp_cnt;
        h       = hold_of(idx);
        exp_ev  = tbl ^ 4'b1000;   // AND is 1 only for {A,B}=11
        exp_cnt = $countones(exp_ev);
        tt[idx]    = tbl;
        start[idx] = 1'b1;
        @(negedge clk);
        if (mode != 2) start[idx] = 1'b0;
        check($sformatf("u%0d start clears err_count", idx), 32'(ec_o[idx]), 0);
        check($sformatf("u%0d start clears err_vec", idx), 32'(ev_o[idx]), 0);
        check($sformatf("u%0d start clears pass", idx), 32'(pass_o[idx]), 0);
        for (int j = 0; j < 4 * h; j++) begin
            check($sformatf("u%0d busy c%0d", idx, j), 32'(busy_o[idx]), 1);
            check($sformatf("u%0d done low c%0d", idx, j), 32'(done_o[idx]), 0);
            check($sformatf("u%0d AB c%0d", idx, j), 32'({a_o[idx], b_o[idx]}), 32'(j / h));
            if (mode == 1) start[idx] = (j == 1);
            @(negedge clk);
        end
        check($sformatf("u%0d done at k+4H", idx), 32'(done_o[idx]), 1);
        check($sformatf("u%0d busy low at done", idx), 32'(busy_o[idx]), 0);
        check($sformatf("u%0d err_vec", idx), 32'(ev_o[idx]), 32'(exp_ev));
        check($sformatf("u%0d err_count", idx), 32'(ec_o[idx]), 32'(exp_cnt));
        check($sformatf("u%0d pass", idx), 32'(pass_o[idx]), 32'(exp_cnt == 0));
        @(negedge clk);
        check($sformatf("u%0d done one cycle", idx), 32'(done_o[idx]), 0);
        check($sformatf("u%0d idle busy", idx), 32'(busy_o[idx]), 0);
        check($sformatf("u%0d idle AB", idx), 32'({a_o[idx], b_o[idx]}), 0);
        check($sformatf("u%0d pass held", idx), 32'(pass_o[idx]), 32'(exp_cnt == 0));
        check($sformatf("u%0d err_vec held", idx), 32'(ev_o[idx]), 32'(exp_ev));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i]   = 1'b1;
            start[i] = 1'b1;          // reset must win over start
            tt[i]    = 4'b1000;
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d reset A", i), 32'(a_o[i]), 0);
            check($sformatf("u%0d reset B", i), 32'(b_o[i]), 0);
            check($sformatf("u%0d reset busy", i), 32'(busy_o[i]), 0);
            check($sformatf("u%0d reset done", i), 32'(done_o[i]), 0);
            check($sformatf("u%0d reset pass", i), 32'(pass_o[i]), 0);
            check($sformatf("u%0d reset err_count", i), 32'(ec_o[i]), 0);
            check($sformatf("u%0d reset err_vec", i), 32'(ev_o[i]), 0);
            rst[i]   = 1'b0;
            start[i] = 1'b0;
        end
        @(negedge clk);

        // Correct AND, H=4; Y stuck at 0, H=4; OR gate, H=2.
        run_check(0, 4'b1000, 0);
        run_check(0, 4'b0000, 0);
        run_check(1, 4'b1110, 0);

        // Extra start pulse during HOLD is ignored.
        run_check(0, 4'b1000, 1);

        // Start held high: second run starts in the IDLE cycle after REPORT.
        run_check(0, 4'b0000, 2);
        run_check(0, 4'b1000, 0);

        // Reset during vector 2 after mismatches on vectors 0 and 1.
        tt[0]    = 4'b1011;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int j = 0; j < 2 * hold_of(0) + 1; j++) @(negedge clk);
        check("u0 partial err_vec before reset", 32'(ev_o[0]), 32'(4'b0011));
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check("u0 mid reset AB", 32'({a_o[0], b_o[0]}), 0);
        check("u0 mid reset busy", 32'(busy_o[0]), 0);
        check("u0 mid reset err_count", 32'(ec_o[0]), 0);
        check("u0 mid reset err_vec", 32'(ev_o[0]), 0);
        check("u0 mid reset pass", 32'(pass_o[0]), 0);
        for (int j = 0; j < 4 * hold_of(0) + 4; j++) begin
            check($sformatf("u0 no done after reset c%0d", j), 32'(done_o[0]), 0);
            @(negedge clk);
        end
        run_check(0, 4'b1000, 0);

        // H=1 with correct gate.
        run_check(2, 4'b1000, 0);

        // Random gate truth tables on every instance.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) begin
                run_check(i, 4'($urandom), 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
